rx_fifo: RTL

- Receive buffer sitting directly downstream of the UART line receiver.
- Captures each received byte presented as a one-cycle write strobe plus 8-bit data, and holds it until the consuming logic reads it.
- Provides registered read data, full/empty/fill-level status, and a sticky overflow flag for bytes lost while full.
- Single clock domain throughout, so no pointer synchronisation is needed.

---
 rtl/rx_fifo_if.sv | 27 ++
 rtl/rx_fifo.sv | 100 ++++++++++
 2 files changed

// File: rtl/rx_fifo_if.sv
// Handshake bundle between the UART receive FIFO and its producer/consumer logic.
// The slave modport is the FIFO side and the master modport is the user side.
interface rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_overflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_overflow,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_overflow,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/rx_fifo.sv
// Single-clock receive FIFO behind the UART line receiver. It has registered read
// data, fill-level status and a sticky overflow flag for bytes dropped while full.
module rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic        CLK_50MHz,
    input  logic        ARESETn,
    rx_fifo_if.slave    bus
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE    = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic              overflow_reg, overflow_next;

    logic empty_int;
    logic full_int;
    logic rd_accept;
    logic wr_accept;
    logic wr_drop;

    assign empty_int = (count_reg == '0);
    assign full_int  = (count_reg == FULL_COUNT);

    // A read that frees a slot lets a write proceed even while full. When empty,
    // the read is refused, so there is never a write-through bypass.
    assign rd_accept = bus.rd_en && !empty_int;
    assign wr_accept = bus.wr_en && (!full_int || rd_accept);
    assign wr_drop   = bus.wr_en && !wr_accept;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + CNT_ONE;
        end else if (rd_accept && !wr_accept) begin
            count_next = count_reg - CNT_ONE;
        end

        // A dropped write takes priority over a clear issued in the same cycle.
        if (wr_drop) begin
            overflow_next = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_next = 1'b0;
        end
    end

    // The storage array is not reset; its contents are only observable via rd_ptr.
    always_ff @(posedge CLK_50MHz) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK_50MHz or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            rd_valid_reg <= rd_accept;
            // When full, wr_ptr equals rd_ptr, and the old word is read here.
            if (rd_accept) begin
                rd_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.empty    = empty_int;
    assign bus.full     = full_int;
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;
endmodule
